// File: rtl/usb_in_buf_reader_if.sv
// Write-side and packetizer-side signal bundle for usb_in_buf_reader.
// The producer/packetizer side uses master; the buffer reader uses slave.
interface usb_in_buf_reader_if #(
    parameter int unsigned ADDR_W = 9
);
    logic [ADDR_W-1:0] buf_in_addr;
    logic [7:0]        buf_in_data;
    logic              buf_in_wren;
    logic              buf_in_ready;
    logic              buf_in_commit;
    logic [9:0]        buf_in_commit_len;
    logic              buf_in_commit_ack;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_last;
    logic              tx_zlp;
    logic              tx_ready;
    logic              pkt_ack;
    logic              pkt_retry;

    modport master (
        output buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
        output tx_ready, pkt_ack, pkt_retry,
        input  buf_in_ready, buf_in_commit_ack, tx_data, tx_valid, tx_last, tx_zlp
    );

    modport slave (
        input  buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
        input  tx_ready, pkt_ack, pkt_retry,
        output buf_in_ready, buf_in_commit_ack, tx_data, tx_valid, tx_last, tx_zlp
    );
endinterface

// File: rtl/usb_in_buf_reader.sv
// USB IN packet buffer: byte RAM filled by the producer, then streamed to the packetizer.
// Define BUFF_IN_RETRY_EN to hold each packet until host ACK and replay it on NAK/timeout.
module usb_in_buf_reader #(
    parameter int unsigned BUF_BYTES = 512
) (
    input logic              phy_ulpi_clk,
    input logic              reset,
    usb_in_buf_reader_if.slave bus
);

    localparam int unsigned AW      = $clog2(BUF_BYTES);
    localparam logic [9:0]  MAX_LEN = 10'(BUF_BYTES);

`ifdef BUFF_IN_RETRY_EN
    typedef enum logic [1:0] {StIdle, StLoad, StSend, StWaitHs} state_e;
`else
    typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;
`endif

    state_e         state_q, state_d;
    logic [9:0]     len_q, len_d;
    logic [9:0]     cnt_q, cnt_d;
    logic           ready_q;
    logic           ack_q;
    logic [7:0]     rd_q;
    logic [AW-1:0]  rd_addr;
    logic [7:0]     ram [BUF_BYTES];

    logic in_send, accept, is_last, take_commit, wr_en;

    assign in_send     = (state_q == StSend);
    assign accept      = in_send && bus.tx_ready;
    assign is_last     = (len_q == 10'd0) || (cnt_q == len_q - 10'd1);
    assign take_commit = (state_q == StIdle) && ready_q && bus.buf_in_commit;
    assign wr_en       = (state_q == StIdle) && ready_q && bus.buf_in_wren;

`ifndef BUFF_IN_RETRY_EN
    logic unused_hs;
    assign unused_hs = bus.pkt_ack ^ bus.pkt_retry;
`endif

    // State register
    always_ff @(posedge phy_ulpi_clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (take_commit) state_d = StLoad;
            StLoad: state_d = StSend;
            StSend: begin
                if (accept && is_last) begin
`ifdef BUFF_IN_RETRY_EN
                    state_d = StWaitHs;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef BUFF_IN_RETRY_EN
            StWaitHs: begin
                // ACK takes priority over a simultaneous retry
                if (bus.pkt_ack)        state_d = StIdle;
                else if (bus.pkt_retry) state_d = StLoad;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Length, byte counter and read-address selection
    always_comb begin
        len_d   = len_q;
        cnt_d   = cnt_q;
        rd_addr = '0;
        if (take_commit) begin
            len_d = (bus.buf_in_commit_len > MAX_LEN) ? MAX_LEN : bus.buf_in_commit_len;
        end
        if (state_q == StLoad) begin
            cnt_d = 10'd0;
        end else if (in_send) begin
            // Prefetch the next byte on acceptance so beats stream without bubbles
            if (accept) begin
                cnt_d   = cnt_q + 10'd1;
                rd_addr = cnt_q[AW-1:0] + AW'(1);
            end else begin
                rd_addr = cnt_q[AW-1:0];
            end
        end
    end

    always_ff @(posedge phy_ulpi_clk or posedge reset) begin
        if (reset) begin
            len_q   <= 10'd0;
            cnt_q   <= 10'd0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == StIdle);
            ack_q   <= take_commit;
        end
    end

    always_ff @(posedge phy_ulpi_clk) begin
        if (wr_en) begin
            ram[bus.buf_in_addr] <= bus.buf_in_data;
        end
        rd_q <= ram[rd_addr];
    end

    // Outputs
    always_comb begin
        bus.tx_valid          = in_send;
        bus.tx_last           = in_send && is_last;
        bus.tx_zlp            = in_send && (len_q == 10'd0);
        bus.tx_data           = (in_send && (len_q != 10'd0)) ? rd_q : 8'h00;
        bus.buf_in_ready      = ready_q;
        bus.buf_in_commit_ack = ack_q;
    end

endmodule

// File: doc/usb_in_buf_reader.md
USB_IN_BUF_READER -- requirements
Module: usb_in_buf_reader

Interface
REQ-001 SHALL have parameter: BUF_BYTES, 512, IN-buffer capacity in bytes (buf_in_addr is 9 bits).
REQ-002 SHALL have ports (name direction width meaning):
- phy_ulpi_clk  in  1  sole clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- buf_in_addr  in  9  write byte address.
- buf_in_data  in  8  write byte.
- buf_in_wren  in  1  write strobe.
- buf_in_ready  out  1  buffer free, writes/commit accepted.
- buf_in_commit  in  1  commit request.
- buf_in_commit_len  in  10  committed packet length in bytes.
- buf_in_commit_ack  out  1  one-cycle commit acknowledge.
- tx_data  out  8  packet byte to packetizer.
- tx_valid  out  1  tx_data valid.
- tx_last  out  1  final beat of packet.
- tx_zlp  out  1  beat is a zero-length-packet marker.
- tx_ready  in  1  packetizer accepts beat.
- pkt_ack  in  1  host ACK for the sent packet.
- pkt_retry  in  1  host NAK/timeout; resend packet.

Function
REQ-003 SHALL hold a BUF_BYTES x 8 RAM: synchronous write, registered read.
REQ-004 SHALL use FSM states IDLE, LOAD, SEND, WAIT_HS.
REQ-005 IDLE: buf_in_ready=1; buf_in_wren writes buf_in_data to buf_in_addr; writes while buf_in_ready=0 are ignored.
REQ-006 IDLE with buf_in_commit=1: SHALL latch len = min(buf_in_commit_len, 512), pulse buf_in_commit_ack for exactly the next cycle, drop buf_in_ready that same cycle, and go to LOAD.
REQ-007 A write and a commit in the same cycle SHALL both take effect; the written byte belongs to the committed packet.
REQ-008 buf_in_commit outside IDLE SHALL be ignored, with no ack.
REQ-009 LOAD: SHALL issue the read of address 0 and reset the 10-bit byte counter; go to SEND next cycle, so the first tx_valid occurs 2 cycles after commit is sampled.
REQ-010 SEND: tx_valid SHALL hold with tx_data stable until tx_ready=1.
- On each accepted beat (tx_valid & tx_ready): counter increments; next address is prefetched so back-to-back beats occur with no bubble.
REQ-011 tx_last SHALL be 1 exactly on the beat with counter = len-1.
REQ-012 len=0: SHALL emit one beat with tx_valid=1, tx_last=1, tx_zlp=1, tx_data=0x00; tx_zlp SHALL be 0 on all other beats.
REQ-013 After the last beat is accepted, the FSM SHALL go to WAIT_HS; tx_valid SHALL be 0 there.
REQ-014 WAIT_HS:
- pkt_ack -> IDLE, buf_in_ready=1 next cycle.
- pkt_retry -> LOAD, replaying identical bytes.
- Both asserted together: pkt_ack wins.
REQ-015 pkt_ack/pkt_retry outside WAIT_HS SHALL be ignored.

Reset
REQ-016 reset SHALL asynchronously force IDLE, counter=0, len=0, and buf_in_ready=0, buf_in_commit_ack=0, tx_valid=0, tx_last=0, tx_zlp=0, tx_data=0x00.
REQ-017 buf_in_ready SHALL rise on the first clock edge after reset deasserts.
REQ-018 Reset mid-packet SHALL abort the transfer with no further beats; RAM contents are not cleared.

Configuration
REQ-019 With macro BUFF_IN_RETRY_EN defined: behaviour per REQ-013..015.
REQ-020 Without BUFF_IN_RETRY_EN: WAIT_HS SHALL NOT exist; after the last beat is accepted the FSM goes to IDLE; pkt_ack and pkt_retry are ignored.

Verification
REQ-021 Write 0x00..0x07 to addr 0..7, commit len=8, tx_ready=1 -> commit_ack 1 cycle; tx_data 0x00..0x07 on 8 consecutive cycles starting 2 cycles after commit; tx_last only on 0x07.
REQ-022 Commit len=0 -> single beat with tx_zlp=1, tx_last=1, tx_data=0x00; then WAIT_HS.
REQ-023 len=4, tx_ready toggling 1/0 -> each byte held stable while stalled; exactly 4 accepted beats.
REQ-024 (BUFF_IN_RETRY_EN) len=3 sent, pkt_retry -> same 3 bytes resent; then pkt_ack -> buf_in_ready=1 next cycle.
REQ-025 Commit len=600 -> exactly 512 beats; writes during SEND do not alter the RAM.
REQ-026 reset asserted on beat 2 of 6 -> tx_valid=0 immediately; buf_in_ready=1 one edge after release.
